// File: rtl/apb3_slave_regs.sv
// ---------------------------------------------------------------------------
// apb3_slave_regs
//
// APB3 completer terminating a bus slot with a bank of 32-bit read/write
// control registers. Transfers can be stretched by a fixed number of wait
// states; misaligned or out-of-range accesses complete with PSLVERR and have
// no side effects. All registers are exported as one flat vector, with a
// one-cycle write pulse per register for the surrounding core.
//
// Ports:
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   apb3_psel     slave select
//   apb3_penable  access phase marker
//   apb3_pwrite   1 = write, 0 = read
//   apb3_paddr    byte address; word index is paddr[AW-1:2]
//   apb3_pwdata   write data, sampled in the setup phase
//   apb3_pready   transfer completion (registered)
//   apb3_prdata   read data (registered), nonzero only while pready=1
//   apb3_pslverr  error response (registered), valid while pready=1
//   cr_regs       register contents, register i at [32i+31:32i]
//   cr_wr_pulse   bit i high for one cycle when register i has been written
// ---------------------------------------------------------------------------
module apb3_slave_regs #(
    parameter int unsigned APB_ADDR_WIDTH_P = 8,
    parameter int unsigned APB_DATA_WIDTH_P = 32,
    parameter int unsigned NR_OF_REGS_P     = 16,
    parameter int unsigned WAIT_STATES_P    = 0
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     apb3_psel,
    input  logic                                     apb3_penable,
    input  logic                                     apb3_pwrite,
    input  logic [APB_ADDR_WIDTH_P-1:0]              apb3_paddr,
    input  logic [APB_DATA_WIDTH_P-1:0]              apb3_pwdata,
    output logic                                     apb3_pready,
    output logic [APB_DATA_WIDTH_P-1:0]              apb3_prdata,
    output logic                                     apb3_pslverr,
    output logic [NR_OF_REGS_P*APB_DATA_WIDTH_P-1:0] cr_regs,
    output logic [NR_OF_REGS_P-1:0]                  cr_wr_pulse
);

    localparam int unsigned IDX_W = APB_ADDR_WIDTH_P - 2;
    localparam int unsigned DW    = APB_DATA_WIDTH_P;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    logic [3:0]                 cnt_q, cnt_d;
    logic [IDX_W-1:0]           idx_q, req_idx, op_idx;
    logic                       write_q, err_q, req_err, op_write, op_err;
    logic [DW-1:0]              wdata_q, op_wdata, rd_word;
    logic [NR_OF_REGS_P*DW-1:0] regs_q;
    logic                       setup, latch, complete;

    assign setup   = apb3_psel & ~apb3_penable;
    assign req_idx = apb3_paddr[APB_ADDR_WIDTH_P-1:2];
    assign req_err = (apb3_paddr[1:0] != 2'b00) || (32'(req_idx) >= NR_OF_REGS_P);

    // pready is registered, so completion is decided one edge ahead of the
    // cycle in which it is seen: at the setup edge when there are no wait
    // states, otherwise on the edge where the counter reaches 1. The state
    // therefore reads DONE during the cycle that pready is high.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        latch    = 1'b0;
        complete = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (setup) begin
                    latch = 1'b1;
                    if (WAIT_STATES_P == 0) begin
                        complete = 1'b1;
                        state_d  = DONE;
                    end else begin
                        cnt_d   = 4'(WAIT_STATES_P);
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (!apb3_psel) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q > 4'd1) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    complete = 1'b1;
                    cnt_d    = '0;
                    state_d  = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Transfer attributes come straight from the bus when completing on the
    // same edge that latches them (zero wait states).
    assign op_idx   = latch ? req_idx     : idx_q;
    assign op_write = latch ? apb3_pwrite : write_q;
    assign op_err   = latch ? req_err     : err_q;
    assign op_wdata = latch ? apb3_pwdata : wdata_q;

    always_comb begin
        rd_word = '0;
        for (int unsigned i = 0; i < NR_OF_REGS_P; i++) begin
            if (op_idx == IDX_W'(i)) begin
                rd_word = regs_q[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            write_q      <= 1'b0;
            err_q        <= 1'b0;
            wdata_q      <= '0;
            regs_q       <= '0;
            apb3_pready  <= 1'b0;
            apb3_pslverr <= 1'b0;
            apb3_prdata  <= '0;
            cr_wr_pulse  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (latch) begin
                idx_q   <= req_idx;
                write_q <= apb3_pwrite;
                err_q   <= req_err;
                wdata_q <= apb3_pwdata;
            end
            apb3_pready  <= complete;
            apb3_pslverr <= complete & op_err;
            apb3_prdata  <= (complete && !op_write && !op_err) ? rd_word : '0;
            cr_wr_pulse  <= '0;
            if (complete && op_write && !op_err) begin
                for (int unsigned i = 0; i < NR_OF_REGS_P; i++) begin
                    if (op_idx == IDX_W'(i)) begin
                        regs_q[i*DW +: DW] <= op_wdata;
                        cr_wr_pulse[i]     <= 1'b1;
                    end
                end
            end
        end
    end

    assign cr_regs = regs_q;

endmodule

// File: tb/tb_apb3_slave_regs.sv
module tb_apb3_slave_regs;

    typedef struct {
        logic [31:0]  prdata;
        logic         slverr;
        logic [15:0]  pulse;
        logic [511:0] regs;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   psel;
    logic         penable, pwrite;
    logic [7:0]   paddr;
    logic [31:0]  pwdata;
    logic [1:0]   pready, pslverr;
    logic [31:0]  prdata  [2];
    logic [511:0] cr_regs [2];
    logic [15:0]  pulse   [2];

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t me;
    logic [511:0] mregs [2];
    logic [1:0]   prev_rdy = 2'b00;

    always #5 clk = ~clk;

    // dut0: no wait states, dut1: three wait states
    apb3_slave_regs #(.APB_ADDR_WIDTH_P(8), .APB_DATA_WIDTH_P(32),
                      .NR_OF_REGS_P(16), .WAIT_STATES_P(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .apb3_psel(psel[0]), .apb3_penable(penable),
        .apb3_pwrite(pwrite), .apb3_paddr(paddr), .apb3_pwdata(pwdata),
        .apb3_pready(pready[0]), .apb3_prdata(prdata[0]), .apb3_pslverr(pslverr[0]),
        .cr_regs(cr_regs[0]), .cr_wr_pulse(pulse[0]));

    apb3_slave_regs #(.APB_ADDR_WIDTH_P(8), .APB_DATA_WIDTH_P(32),
                      .NR_OF_REGS_P(16), .WAIT_STATES_P(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .apb3_psel(psel[1]), .apb3_penable(penable),
        .apb3_pwrite(pwrite), .apb3_paddr(paddr), .apb3_pwdata(pwdata),
        .apb3_pready(pready[1]), .apb3_prdata(prdata[1]), .apb3_pslverr(pslverr[1]),
        .cr_regs(cr_regs[1]), .cr_wr_pulse(pulse[1]));

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: pops one expectation per completed transfer.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst_n && pready[d]) begin
                if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_pready dut%0d: got pready=1 expected 0", d);
                end else begin
                    if (d == 0) me = q0.pop_front();
                    else        me = q1.pop_front();
                    check($sformatf("prdata_dut%0d", d),  512'(prdata[d]),  512'(me.prdata));
                    check($sformatf("pslverr_dut%0d", d), 512'(pslverr[d]), 512'(me.slverr));
                    check($sformatf("wr_pulse_dut%0d", d), 512'(pulse[d]),  512'(me.pulse));
                    check($sformatf("cr_regs_dut%0d", d), cr_regs[d],       me.regs);
                end
            end else if (rst_n && prev_rdy[d]) begin
                check($sformatf("after_done_dut%0d", d),
                      {pulse[d], pready[d], pslverr[d], prdata[d]}, '0);
            end
            prev_rdy[d] = pready[d];
        end
    end

    task automatic xfer(input int d, input bit wr, input logic [7:0] addr,
                        input logic [31:0] data, output int acc, output time t_done);
        exp_t e;
        int   idx;
        bit   legal;
        idx   = int'(addr[7:2]);
        legal = (addr[1:0] == 2'b00) && (idx < 16);
        e.slverr = !legal;
        e.prdata = '0;
        e.pulse  = '0;
        if (legal && !wr) e.prdata = mregs[d][idx*32 +: 32];
        if (legal && wr) begin
            mregs[d][idx*32 +: 32] = data;
            e.pulse = 16'(1) << idx;
        end
        e.regs = mregs[d];
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
        @(posedge clk); #1;
        psel = '0; psel[d] = 1'b1; penable = 1'b0;
        pwrite = wr; paddr = addr; pwdata = data;
        @(posedge clk); #1;
        penable = 1'b1;
        acc = 0;
        forever begin
            @(negedge clk);
            acc++;
            if (pready[d]) break;
            if (acc > 40) begin
                check("pready_timeout", 512'(pready[d]), 512'(1));
                break;
            end
        end
        t_done = $time;
    endtask

    task automatic idle();
        @(posedge clk); #1;
        psel = '0; penable = 1'b0;
    endtask

    initial begin
        int   acc;
        time  t1, t2, t3, t4;
        logic seen;

        rst_n = 1'b0; psel = '0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0;
        mregs[0] = '0; mregs[1] = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("reset_outputs_dut%0d", d),
                  {pulse[d], pready[d], pslverr[d], prdata[d]}, '0);
            check($sformatf("reset_regs_dut%0d", d), cr_regs[d], '0);
        end

        // Basic write/read, no wait states
        xfer(0, 1'b1, 8'h08, 32'hDEADBEEF, acc, t1);
        check("w0_latency", 512'(acc), 512'(1));
        idle();
        xfer(0, 1'b0, 8'h08, 32'h0, acc, t1);
        idle();

        // Illegal accesses
        xfer(0, 1'b1, 8'h40, 32'h11111111, acc, t1);
        idle();
        xfer(0, 1'b0, 8'h06, 32'h0, acc, t1);
        idle();

        // Last register (boundary of the legal range)
        xfer(0, 1'b1, 8'h3C, 32'hCAFEF00D, acc, t1);
        idle();
        xfer(0, 1'b0, 8'h3C, 32'h0, acc, t1);
        idle();

        // Back-to-back: each setup follows the completion cycle directly
        xfer(0, 1'b1, 8'h00, 32'd1, acc, t1);
        xfer(0, 1'b1, 8'h04, 32'd2, acc, t2);
        xfer(0, 1'b1, 8'h08, 32'd3, acc, t3);
        xfer(0, 1'b0, 8'h04, 32'h0, acc, t4);
        check("b2b_gap1", 512'(t2 - t1), 512'(20));
        check("b2b_gap2", 512'(t3 - t2), 512'(20));
        check("b2b_gap3", 512'(t4 - t3), 512'(20));
        idle();

        // penable without a setup phase must be ignored
        @(posedge clk); #1;
        psel = 2'b01; penable = 1'b1; pwrite = 1'b1; paddr = 8'h00; pwdata = 32'hFFFFFFFF;
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            seen |= pready[0];
        end
        check("no_setup_no_pready", 512'(seen), 512'(0));
        check("no_setup_regs", cr_regs[0], mregs[0]);
        idle();

        // Three wait states
        xfer(1, 1'b0, 8'h00, 32'h0, acc, t1);
        check("ws3_read_latency", 512'(acc), 512'(4));
        idle();
        xfer(1, 1'b1, 8'h04, 32'hA5A5A5A5, acc, t1);
        check("ws3_write_latency", 512'(acc), 512'(4));
        xfer(1, 1'b0, 8'h04, 32'h0, acc, t1);
        idle();

        // Abort: psel dropped during a wait state
        @(posedge clk); #1;
        psel = 2'b10; penable = 1'b0; pwrite = 1'b1; paddr = 8'h0C; pwdata = 32'h55AA55AA;
        @(posedge clk); #1 penable = 1'b1;
        @(posedge clk); #1 psel = '0; penable = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen |= pready[1] | (pulse[1] != 16'h0);
        end
        check("abort_no_response", 512'(seen), 512'(0));
        check("abort_regs", cr_regs[1], mregs[1]);

        // Reset during the access phase of a write
        @(posedge clk); #1;
        psel = 2'b10; penable = 1'b0; pwrite = 1'b1; paddr = 8'h08; pwdata = 32'h12345678;
        @(posedge clk); #1 penable = 1'b1;
        @(posedge clk); #3 rst_n = 1'b0;
        #1;
        check("rst_mid_outputs", {pulse[1], pready[1], pslverr[1], prdata[1]}, '0);
        check("rst_mid_regs1", cr_regs[1], '0);
        check("rst_mid_regs0", cr_regs[0], '0);
        psel = '0; penable = 1'b0;
        mregs[0] = '0; mregs[1] = '0;
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("rst_after_regs1", cr_regs[1], '0);
        check("rst_after_ready", 512'(pready[1]), 512'(0));

        check("scoreboard_drained", 512'(q0.size() + q1.size()), 512'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
